bo_poly: RTL

- Parametrised successor to the fixed 16-bit operative block: evaluates an unsigned polynomial Resultado = c[N-1]·X^(N-1) + … + c[1]·X + c[0] using Horner's rule.
- Datapath and control live in one block: a shift-add multiplier and adder, sequenced by an internal FSM, behind a start/ready/done handshake.
- Replaces the externally driven load/mux-select control of the previous generation. Sits between the operand source and the result consumer.

---
 rtl/bo_poly_pkg.sv | 13 +
 rtl/bo_poly_if.sv | 18 +
 rtl/bo_shift_add_mul.sv | 52 +++++
 rtl/bo_poly.sv | 105 ++++++++++
 4 files changed

// File: rtl/bo_poly_pkg.sv
// bo_poly_pkg: shared state encoding, default widths and width helper for bo_poly.
package bo_poly_pkg;
  localparam int WIDTH_DEF = 16;
  localparam int XW_DEF = 8;
  localparam int N_COEF_DEF = 3;
  typedef enum logic [1:0] {IDLE, MUL, ADD, DONE} state_e;
  function automatic int clog2(input int v);
    int r;
    r = 1;
    for (int i = 1; i < 31; i++) r = ((1 << i) < v) ? i + 1 : r;
    return r;
  endfunction
endpackage

// File: rtl/bo_poly_if.sv
// bo_poly_if: start/ready/done handshake, operands and result of bo_poly.
interface bo_poly_if
  import bo_poly_pkg::*;
#(
  parameter int WIDTH = WIDTH_DEF,
  parameter int XW = XW_DEF,
  parameter int N_COEF = N_COEF_DEF
);
  logic start;
  logic ready;
  logic [XW-1:0] X;
  logic [N_COEF*WIDTH-1:0] coef;
  logic [WIDTH-1:0] Resultado;
  logic Overflow;
  logic done;
  modport master(output start, X, coef, input ready, Resultado, Overflow, done);
  modport slave(input start, X, coef, output ready, Resultado, Overflow, done);
endinterface

// File: rtl/bo_shift_add_mul.sv
// bo_shift_add_mul: XW-cycle LSB-first shift-add multiplier, truncated to WIDTH with sticky overflow.
module bo_shift_add_mul
  import bo_poly_pkg::*;
#(
  parameter int WIDTH = WIDTH_DEF,
  parameter int XW = XW_DEF
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [WIDTH-1:0] a,
  input  logic [XW-1:0]    x,
  output logic [WIDTH-1:0] prod,
  output logic             ovf,
  output logic             done
);
  localparam int CW = clog2(XW);
  logic [WIDTH-1:0] a_q, a_d, prod_q, prod_d;
  logic [XW-1:0] x_q, x_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic busy_q, busy_d, ovf_q, ovf_d;
  logic [WIDTH+XW-1:0] sum;
  assign done = busy_q && cnt_q == CW'(XW - 1);
  assign prod = prod_q;
  assign ovf = ovf_q;
  always_comb begin
    sum = (WIDTH+XW)'(prod_q) + (((WIDTH+XW)'(a_q)) << cnt_q);
    a_d = start ? a : a_q;
    x_d = start ? x : x_q;
    prod_d = start ? '0 : (busy_q && x_q[cnt_q]) ? sum[WIDTH-1:0] : prod_q;
    ovf_d = start ? 1'b0 : ovf_q | (busy_q && x_q[cnt_q] && |sum[WIDTH+XW-1:WIDTH]);
    cnt_d = start ? '0 : busy_q ? cnt_q + CW'(1) : cnt_q;
    busy_d = start | (busy_q & ~done);
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      a_q <= '0;
      x_q <= '0;
      prod_q <= '0;
      ovf_q <= 1'b0;
      cnt_q <= '0;
      busy_q <= 1'b0;
    end else begin
      a_q <= a_d;
      x_q <= x_d;
      prod_q <= prod_d;
      ovf_q <= ovf_d;
      cnt_q <= cnt_d;
      busy_q <= busy_d;
    end
  end
endmodule

// File: rtl/bo_poly.sv
// bo_poly: Horner polynomial evaluator with internal FSM and shift-add multiplier.
// Define BO_POLY_SAT_EN to saturate Resultado to all-ones when an operation overflows.
module bo_poly
  import bo_poly_pkg::*;
#(
  parameter int WIDTH = WIDTH_DEF,
  parameter int XW = XW_DEF,
  parameter int N_COEF = N_COEF_DEF
) (
  input logic clk,
  input logic rst,
  bo_poly_if.slave bus
);
  localparam int IW = clog2(N_COEF);
  localparam int IDX0 = N_COEF > 1 ? N_COEF - 2 : 0;
  state_e state_q, state_d;
  logic [XW-1:0] x_q, x_d;
  logic [N_COEF*WIDTH-1:0] coef_q, coef_d;
  logic [IW-1:0] idx_q, idx_d;
  logic ovf_q, ovf_d, ovf_out_q, ovf_out_d, done_q, done_d;
  logic [WIDTH-1:0] res_q, res_d, top, fin, mul_a, mul_prod;
  logic [XW-1:0] mul_x;
  logic [WIDTH:0] sum;
  logic accept, ovf_n, mul_start, mul_ovf, mul_done;
  assign bus.ready = state_q == IDLE && !rst;
  assign bus.Resultado = res_q;
  assign bus.Overflow = ovf_out_q;
  assign bus.done = done_q;
  assign accept = bus.start & bus.ready;
  assign top = bus.coef[(N_COEF-1)*WIDTH +: WIDTH];
  assign sum = {1'b0, mul_prod} + {1'b0, coef_q[idx_q*WIDTH +: WIDTH]};
  assign ovf_n = ovf_q | mul_ovf | sum[WIDTH];
  // Next multiply operand comes straight from the inputs on accept, else from this ADD's sum.
  assign mul_a = state_q == IDLE ? top : sum[WIDTH-1:0];
  assign mul_x = state_q == IDLE ? bus.X : x_q;
`ifdef BO_POLY_SAT_EN
  assign fin = ovf_n ? '1 : sum[WIDTH-1:0];
`else
  assign fin = sum[WIDTH-1:0];
`endif
  bo_shift_add_mul #(.WIDTH(WIDTH), .XW(XW)) u_mul (
    .clk(clk), .rst(rst), .start(mul_start), .a(mul_a), .x(mul_x),
    .prod(mul_prod), .ovf(mul_ovf), .done(mul_done)
  );
  always_comb begin
    state_d = state_q;
    x_d = x_q;
    coef_d = coef_q;
    idx_d = idx_q;
    ovf_d = ovf_q;
    res_d = res_q;
    ovf_out_d = ovf_out_q;
    done_d = 1'b0;
    mul_start = 1'b0;
    case (state_q)
      IDLE: if (accept) begin
        x_d = bus.X;
        coef_d = bus.coef;
        idx_d = IW'(IDX0);
        ovf_d = 1'b0;
        mul_start = N_COEF > 1;
        state_d = N_COEF > 1 ? MUL : DONE;
        res_d = N_COEF > 1 ? res_q : top;
        ovf_out_d = N_COEF > 1 ? ovf_out_q : 1'b0;
        done_d = N_COEF == 1;
      end
      MUL: state_d = mul_done ? ADD : MUL;
      ADD: begin
        ovf_d = ovf_n;
        if (idx_q == '0) begin
          state_d = DONE;
          res_d = fin;
          ovf_out_d = ovf_n;
          done_d = 1'b1;
        end else begin
          idx_d = idx_q - IW'(1);
          mul_start = 1'b1;
          state_d = MUL;
        end
      end
      default: state_d = IDLE;
    endcase
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      x_q <= '0;
      coef_q <= '0;
      idx_q <= '0;
      ovf_q <= 1'b0;
      res_q <= '0;
      ovf_out_q <= 1'b0;
      done_q <= 1'b0;
    end else begin
      state_q <= state_d;
      x_q <= x_d;
      coef_q <= coef_d;
      idx_q <= idx_d;
      ovf_q <= ovf_d;
      res_q <= res_d;
      ovf_out_q <= ovf_out_d;
      done_q <= done_d;
    end
  end
endmodule
